// File: rtl/aes_pkg.sv
// Shared AES definitions for the iterative round controller: state encoding,
// round-count constants and the byte-level transforms used by the round datapath.
package aes_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RND_A,
        RND_B,
        FINAL,
        DONE
    } round_state_e;

    localparam int NR_AES128 = 10;
    localparam int NR_AES192 = 12;
    localparam int NR_AES256 = 14;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // Byte n of the block lives at bits [127-8n -: 8]; n = 4*column + row.
    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int n = 0; n < 16; n++) begin
            r[127 - 8*n -: 8] = sbox(s[127 - 8*n -: 8]);
        end
        return r;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 8*(4*c + row) -: 8] = s[127 - 8*(4*((c + row) % 4) + row) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            r[127 - 32*c -: 8] = gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3;
            r[119 - 32*c -: 8] = a0 ^ gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3;
            r[111 - 32*c -: 8] = a0 ^ a1 ^ gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03);
            r[103 - 32*c -: 8] = gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul(a3, 8'h02);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_round_dp.sv
// Shared AES round datapath: combinational SubBytes+ShiftRows feeding a
// MixColumns stage whose result is registered for one cycle.
module aes_round_dp
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] state_in,
    input  logic         mix_load,
    output logic [127:0] sr_out,
    output logic [127:0] mix_out
);

    assign sr_out = shift_rows(sub_bytes(state_in));

    // The MixColumns result is captured only when the controller is in the
    // first half of a round, so it stays put while AddRoundKey consumes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mix_out <= '0;
        end else if (mix_load) begin
            mix_out <= mix_columns(sr_out);
        end
    end

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES encryption round controller: accepts a block, runs NR rounds on
// the shared datapath with externally fetched round keys and returns ciphertext.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR = NR_AES128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    // An unsupported round count falls back to the AES-128 schedule.
    localparam int NR_EFF = (NR == NR_AES192 || NR == NR_AES256) ? NR : NR_AES128;
    localparam logic [3:0] LAST_MID  = 4'(NR_EFF - 1);
    localparam logic [3:0] FINAL_IDX = 4'(NR_EFF);

    round_state_e state;
    logic [3:0]   round;
    logic [127:0] state_reg;
    logic [127:0] sr_out;
    logic [127:0] mix_out;
    logic         mix_load;
    logic         round_ok;

    assign mix_load = (state == RND_A);
    assign round_ok = (round >= 4'd1) && (round <= LAST_MID);

    aes_round_dp u_dp (
        .clk      (clk),
        .rst      (rst),
        .state_in (state_reg),
        .mix_load (mix_load),
        .sr_out   (sr_out),
        .mix_out  (mix_out)
    );

    always_comb begin
        rk_idx = 4'd0;
        case (state)
            RND_A, RND_B: rk_idx = round;
            FINAL:        rk_idx = FINAL_IDX;
            default:      rk_idx = 4'd0;
        endcase
    end

    // in_ready and busy are registered alongside the state so no input
    // handshake signal ever reaches an output combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            round     <= 4'd0;
            state_reg <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state_reg <= in_data ^ rk;
                        round     <= 4'd1;
                        state     <= RND_A;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                RND_A: begin
                    if (round_ok) begin
                        state <= RND_B;
                    end else begin
                        state    <= IDLE;
                        round    <= 4'd0;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end
                end
                RND_B: begin
                    if (round_ok) begin
                        state_reg <= mix_out ^ rk;
                        round     <= round + 4'd1;
                        if (round == LAST_MID) begin
                            state <= FINAL;
                        end else begin
                            state <= RND_A;
                        end
                    end else begin
                        state    <= IDLE;
                        round    <= 4'd0;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end
                end
                FINAL: begin
                    out_data  <= sr_out ^ rk;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        round     <= 4'd0;
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    round     <= 4'd0;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
